writeback_unit: RTL and testbench

Write-back stage that collects results from the ALU and the load/memory unit and drives the register file's single write port (wr, control, write_back_reg). Both sources can complete in the same cycle, but the register file commits only one write per cycle, so results are buffered in a small in-order FIFO and drained at one write per cycle. A per-register pending-write scoreboard (busy) lets decode stall on read-after-write hazards.

---
 rtl/writeback_unit.sv | 104 ++++++++++
 tb/tb_writeback_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results through an in-order FIFO onto the
// single register-file write port, with a per-register pending-write scoreboard.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_dest,
    input  logic [31:0]                mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_dest,
    input  logic [31:0]                alu_data,
    output logic                       wr,
    output logic [4:0]                 control,
    output logic [31:0]                write_back_reg,
    output logic [15:0]                busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH + 2);

    logic [3:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, alu_slot;
    logic [CW-1:0] count_q, count_d;
    logic          wr_q;
    logic [3:0]    ctl_q;
    logic [31:0]   wbd_q;
    logic [PW-1:0] pend_q [16];
    logic          mem_enq, alu_enq, deq;
    logic [1:0]    enq_n;

    assign mem_ready = count_q < CW'(DEPTH);
    assign alu_ready = count_q < CW'(DEPTH - 1);

    // Destinations >= 16 complete the handshake but never occupy a slot.
    always_comb begin
        mem_enq  = mem_valid && mem_ready && !mem_dest[4];
        alu_enq  = alu_valid && alu_ready && !alu_dest[4];
        deq      = count_q != '0;
        enq_n    = 2'(mem_enq) + 2'(alu_enq);
        alu_slot = wptr_q + AW'(mem_enq);
        wptr_d   = wptr_q + AW'(enq_n);
        rptr_d   = rptr_q + AW'(deq);
        count_d  = count_q + CW'(enq_n) - CW'(deq);
    end

    always_ff @(posedge clock) begin
        if (mem_enq) begin
            dest_q[wptr_q] <= mem_dest[3:0];
            data_q[wptr_q] <= mem_data;
        end
        if (alu_enq) begin
            dest_q[alu_slot] <= alu_dest[3:0];
            data_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            ctl_q   <= '0;
            wbd_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wr_q    <= deq;
            if (deq) begin
                ctl_q <= dest_q[rptr_q];
                wbd_q <= data_q[rptr_q];
            end
        end
    end

    // A register stays busy until the write sitting in the output register retires.
    for (genvar r = 0; r < 16; r++) begin : g_pend
        logic [1:0]    inc;
        logic          dec;
        logic [PW-1:0] pend_d;
        always_comb begin
            inc    = 2'(mem_enq && mem_dest[3:0] == 4'(r)) + 2'(alu_enq && alu_dest[3:0] == 4'(r));
            dec    = wr_q && ctl_q == 4'(r);
            pend_d = pend_q[r] + PW'(inc) - PW'(dec);
        end
        always_ff @(posedge clock) begin
            if (rst) pend_q[r] <= '0;
            else pend_q[r] <= pend_d;
        end
        assign busy[r] = pend_q[r] != '0;
    end

    assign wr             = wr_q;
    assign control        = {1'b0, ctl_q};
    assign write_back_reg = wbd_q;
    assign count          = count_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scenario tests for writeback_unit with hand-computed expectations.
module tb_writeback_unit;
    logic        clock = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_dest, alu_dest;
    logic [31:0] mem_data, alu_data;
    logic        wr;
    logic [4:0]  control;
    logic [31:0] write_back_reg;
    logic [15:0] busy;
    logic [2:0]  count;
    int errors = 0;
    int checks = 0;

    writeback_unit #(.DEPTH(4)) dut (
        .clock(clock), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .wr(wr), .control(control), .write_back_reg(write_back_reg), .busy(busy), .count(count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_valid = 1'b1; mem_dest = 5'd1; mem_data = 32'h1;
        alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'h2;
        tick;
        tick;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", wr); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (write_back_reg !== 32'h0 || control !== 5'd0) begin errors++; $display("FAIL reset_port got %0d/%h exp 0/0", control, write_back_reg); end
        rst = 1'b0;
        idle;
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", mem_ready, alu_ready); end
    endtask

    task automatic test_single;
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
        tick;
        idle;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count0 got %0d exp 1", count); end
        checks++; if (busy !== 16'h0008 || wr !== 1'b0) begin errors++; $display("FAIL single_busy0 got %h/%b exp 0008/0", busy, wr); end
        tick;
        checks++; if (wr !== 1'b1 || control !== 5'd3 || write_back_reg !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write got %b/%0d/%h exp 1/3/deadbeef", wr, control, write_back_reg); end
        checks++; if (count !== 3'd0 || busy !== 16'h0008) begin errors++; $display("FAIL single_state1 got %0d/%h exp 0/0008", count, busy); end
        tick;
        checks++; if (wr !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL single_done got %b/%h exp 0/0000", wr, busy); end
        checks++; if (control !== 5'd3 || write_back_reg !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold got %0d/%h exp 3/deadbeef", control, write_back_reg); end
    endtask

    task automatic test_dual;
        mem_valid = 1'b1; mem_dest = 5'd5; mem_data = 32'h11;
        alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'h22;
        tick;
        idle;
        checks++; if (count !== 3'd2 || busy !== 16'h0060) begin errors++; $display("FAIL dual_queued got %0d/%h exp 2/0060", count, busy); end
        tick;
        checks++; if (wr !== 1'b1 || control !== 5'd5 || write_back_reg !== 32'h11) begin errors++; $display("FAIL dual_first got %b/%0d/%h exp 1/5/11", wr, control, write_back_reg); end
        tick;
        checks++; if (wr !== 1'b1 || control !== 5'd6 || write_back_reg !== 32'h22) begin errors++; $display("FAIL dual_second got %b/%0d/%h exp 1/6/22", wr, control, write_back_reg); end
        checks++; if (busy !== 16'h0040) begin errors++; $display("FAIL dual_busy got %h exp 0040", busy); end
        tick;
        checks++; if (wr !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL dual_done got %b/%h exp 0/0000", wr, busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [8];
        logic [4:0]  exp_d [8];
        logic [2:0]  exp_c [6];
        logic        exp_a [6];
        exp_q = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h103, 32'h104, 32'h105};
        exp_d = '{5'd1, 5'd8, 5'd2, 5'd9, 5'd3, 5'd4, 5'd5, 5'd6};
        exp_c = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        exp_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            mem_valid = 1'b1; mem_dest = 5'(k + 1); mem_data = 32'h100 + 32'(k);
            alu_valid = 1'b1; alu_dest = 5'(k + 8); alu_data = 32'h200 + 32'(k);
            checks++; if (count !== exp_c[k]) begin errors++; $display("FAIL bp_count[%0d] got %0d exp %0d", k, count, exp_c[k]); end
            checks++; if (alu_ready !== exp_a[k] || mem_ready !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d] got %b%b exp 1%b", k, mem_ready, alu_ready, exp_a[k]); end
            if (k >= 2) begin
                checks++; if (wr !== 1'b1 || control !== exp_d[k-2] || write_back_reg !== exp_q[k-2]) begin errors++; $display("FAIL bp_commit[%0d] got %b/%0d/%h exp 1/%0d/%h", k, wr, control, write_back_reg, exp_d[k-2], exp_q[k-2]); end
            end
            tick;
        end
        idle;
        for (int k = 6; k < 10; k++) begin
            checks++; if (wr !== 1'b1 || control !== exp_d[k-2] || write_back_reg !== exp_q[k-2]) begin errors++; $display("FAIL bp_drain[%0d] got %b/%0d/%h exp 1/%0d/%h", k, wr, control, write_back_reg, exp_d[k-2], exp_q[k-2]); end
            tick;
        end
        checks++; if (wr !== 1'b0 || count !== 3'd0 || busy !== 16'h0) begin errors++; $display("FAIL bp_empty got %b/%0d/%h exp 0/0/0000", wr, count, busy); end
    endtask

    task automatic test_same_dest;
        mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'hA;
        alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'hB;
        tick;
        idle;
        checks++; if (busy !== 16'h0080 || count !== 3'd2) begin errors++; $display("FAIL same_queued got %h/%0d exp 0080/2", busy, count); end
        tick;
        checks++; if (wr !== 1'b1 || control !== 5'd7 || write_back_reg !== 32'hA || busy !== 16'h0080) begin errors++; $display("FAIL same_first got %b/%0d/%h/%h exp 1/7/a/0080", wr, control, write_back_reg, busy); end
        tick;
        checks++; if (wr !== 1'b1 || control !== 5'd7 || write_back_reg !== 32'hB || busy !== 16'h0080) begin errors++; $display("FAIL same_second got %b/%0d/%h/%h exp 1/7/b/0080", wr, control, write_back_reg, busy); end
        tick;
        checks++; if (wr !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL same_done got %b/%h exp 0/0000", wr, busy); end
    endtask

    task automatic test_discard_reset;
        alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 32'h55;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL discard_ready got %b exp 1", alu_ready); end
        tick;
        idle;
        checks++; if (count !== 3'd0 || busy !== 16'h0 || wr !== 1'b0) begin errors++; $display("FAIL discard_state got %0d/%h/%b exp 0/0000/0", count, busy, wr); end
        tick;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL discard_nowr got %b exp 0", wr); end
        mem_valid = 1'b1; mem_dest = 5'd1; mem_data = 32'hC1;
        alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'hC2;
        tick;
        alu_valid = 1'b0; mem_dest = 5'd3; mem_data = 32'hC3;
        tick;
        checks++; if (busy !== 16'h000E || count !== 3'd2 || wr !== 1'b1) begin errors++; $display("FAIL prereset got %h/%0d/%b exp 000e/2/1", busy, count, wr); end
        rst = 1'b1;
        mem_valid = 1'b1; alu_valid = 1'b1; alu_dest = 5'd4;
        tick;
        rst = 1'b0;
        idle;
        checks++; if (wr !== 1'b0 || count !== 3'd0 || busy !== 16'h0) begin errors++; $display("FAIL midreset got %b/%0d/%h exp 0/0/0000", wr, count, busy); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (wr !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL postreset[%0d] got %b/%h exp 0/0000", k, wr, busy); end
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        test_reset;
        test_single;
        test_dual;
        test_back_to_back;
        test_same_dest;
        test_discard_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
